// File: rtl/mul_seq_pkg.sv
// Shared encodings for the sequential RV32M multiplier.
package mul_seq_pkg;

   typedef enum logic [1:0] {
      MUL_OP_MUL    = 2'b00,
      MUL_OP_MULH   = 2'b01,
      MUL_OP_MULHSU = 2'b10,
      MUL_OP_MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_SIGN = 2'b10,
      S_DONE = 2'b11
   } state_e;

   // rs1 is treated as signed for MULH and MULHSU
   function automatic logic op_rs1_signed(input mul_op_e op);
      return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
   endfunction

   // rs2 is treated as signed only for MULH
   function automatic logic op_rs2_signed(input mul_op_e op);
      return (op == MUL_OP_MULH);
   endfunction

endpackage

// File: rtl/mul_seq_rca.sv
// N-bit ripple-carry adder shared with the execute stage.
module mul_seq_rca #(
   parameter int unsigned n = 32
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         cin,
   output logic [n-1:0] sum,
   output logic         cout
);

   // bit-serial carry chain, one full adder per bit
   always_comb begin : ripple
      logic c;
      sum = '0;
      c   = cin;
      for (int unsigned i = 0; i < n; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/mul_seq.sv
// Iterative shift-and-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operates on magnitudes and applies the sign at the end.
module mul_seq
   import mul_seq_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] rs1,
   input  logic [N-1:0] rs2,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result
);

   localparam int unsigned CW = $clog2(N);
   localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};

   state_e         state_q, state_d;
   mul_op_e        op_q, op_d;
   logic           neg_q, neg_d;
   logic [N-1:0]   mcand_q, mcand_d;
   logic [N-1:0]   mplier_q, mplier_d;
   logic [N-1:0]   acc_hi_q, acc_hi_d;
   logic [N-1:0]   result_q, result_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   mul_op_e        op_in;
   logic           sgn1, sgn2;
   logic [N-1:0]   rca_b, rca_sum;
   logic           rca_cout;
   logic [2*N-1:0] prod, prod_fix;

   // partial-product addend selected by the current multiplier LSB
   always_comb begin
      rca_b = mplier_q[0] ? mcand_q : '0;
   end

   mul_seq_rca #(.n(N)) u_rca (
      .a    (acc_hi_q),
      .b    (rca_b),
      .cin  (1'b0),
      .sum  (rca_sum),
      .cout (rca_cout)
   );

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= MUL_OP_MUL;
         neg_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_hi_q <= '0;
         result_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_hi_q <= acc_hi_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_CALC;
         S_CALC: if (cnt_q == CW'(N-1)) state_d = S_SIGN;
         S_SIGN: state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // datapath: operand capture, shift-add step, sign fix and half select
   always_comb begin
      op_d     = op_q;
      neg_d    = neg_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_hi_d = acc_hi_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      op_in    = mul_op_e'(op);
      sgn1     = op_rs1_signed(op_in) & rs1[N-1];
      sgn2     = op_rs2_signed(op_in) & rs2[N-1];
      prod     = {acc_hi_q, mplier_q};
      prod_fix = neg_q ? (~prod + ONE_2N) : prod;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d     = op_in;
               neg_d    = sgn1 ^ sgn2;
               // negating the most negative value yields the same bits, read as unsigned
               mcand_d  = sgn1 ? (~rs1 + ONE_N) : rs1;
               mplier_d = sgn2 ? (~rs2 + ONE_N) : rs2;
               acc_hi_d = '0;
               cnt_d    = '0;
            end
         end
         S_CALC: begin
            acc_hi_d = {rca_cout, rca_sum[N-1:1]};
            mplier_d = {rca_sum[0], mplier_q[N-1:1]};
            cnt_d    = cnt_q + CW'(1);
         end
         S_SIGN: begin
            result_d = (op_q == MUL_OP_MUL) ? prod_fix[N-1:0] : prod_fix[2*N-1:N];
         end
         default: ;
      endcase
   end

   // handshake outputs decoded from state
   always_comb begin
      busy   = (state_q == S_CALC) || (state_q == S_SIGN);
      done   = (state_q == S_DONE);
      result = result_q;
   end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed cases plus randomized operations
// compared against a 64-bit arithmetic reference.
module tb_mul_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic        busy, done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   mul_seq #(.N(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .rs1    (rs1),
      .rs2    (rs2),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   // reference: sign/zero-extend to 64 bits, multiply, pick the half
   function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint x, y, p;
      x = (o == 2'b01 || o == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
      y = (o == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
      p = x * y;
      return (o == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // run one operation; optionally pulse start and change operands mid-flight
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit disturb);
      int cyc, busy_cnt, extra_done;
      logic [31:0] exp;
      exp = ref_mul(o, a, b);
      @(negedge clk);
      start = 1'b1; op = o; rs1 = a; rs2 = b;
      @(negedge clk);
      start = 1'b0;
      rs1 = $urandom; rs2 = $urandom; op = 2'($urandom);
      cyc = 1; busy_cnt = 0;
      while (!done && cyc < 200) begin
         if (busy) busy_cnt++;
         if (disturb && cyc == 5) begin
            start = 1'b1; rs1 = $urandom; rs2 = $urandom; op = 2'($urandom);
         end
         if (disturb && cyc == 9) start = 1'b0;
         @(negedge clk);
         cyc++;
      end
      chk("latency", 32'(cyc), 32'd34);
      chk("busy_cycles", 32'(busy_cnt), 32'd33);
      chk("busy_in_done", {31'b0, busy}, 32'd0);
      chk("result", result, exp);
      @(negedge clk);
      chk("done_low_after", {31'b0, done}, 32'd0);
      chk("result_hold", result, exp);
      if (disturb) begin
         extra_done = 0;
         for (int i = 0; i < 5; i++) begin
            if (done || busy) extra_done++;
            @(negedge clk);
         end
         chk("no_queued_op", 32'(extra_done), 32'd0);
      end
   endtask

   initial begin
      int aborted;
      logic [1:0]  ro;
      logic [31:0] ra, rb;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      rst = 1'b0;

      // directed cases
      run_op(2'b00, 32'd7, 32'd6, 1'b0);
      chk("mul_7x6_const", result, 32'h0000002A);
      run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      chk("mulhu_ff_const", result, 32'hFFFFFFFE);
      run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      chk("mul_ff_const", result, 32'h00000001);
      run_op(2'b01, 32'h80000000, 32'h80000000, 1'b0);
      chk("mulh_min_const", result, 32'h40000000);
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      chk("mulh_m1_const", result, 32'h00000000);
      run_op(2'b10, 32'hFFFFFFFE, 32'd3, 1'b0);
      chk("mulhsu_const", result, 32'hFFFFFFFF);
      run_op(2'b11, 32'hFFFFFFFE, 32'd3, 1'b0);
      chk("mulhu_const", result, 32'h00000002);
      run_op(2'b01, 32'd0, 32'h80000001, 1'b0);
      chk("zero_operand", result, 32'h00000000);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);

      // start and operand changes during CALC are ignored
      run_op(2'b01, 32'h12345678, 32'hFEDCBA98, 1'b1);

      // reset mid-operation aborts with no done
      @(negedge clk);
      start = 1'b1; op = 2'b00; rs1 = 32'd9; rs2 = 32'd11;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_result", result, 32'd0);
      rst = 1'b0;
      aborted = 0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy) aborted++;
         @(negedge clk);
      end
      chk("abort_no_done", 32'(aborted), 32'd0);
      run_op(2'b00, 32'd3, 32'd5, 1'b0);
      chk("mul_3x5_const", result, 32'h0000000F);

      // randomized operations, including extreme operand values
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h80000000;
            1: rb = 32'hFFFFFFFF;
            2: ra = 32'd0;
            default: ;
         endcase
         run_op(ro, ra, rb, 1'b0);
      end

      // low half must not depend on the op encoding
      ra = $urandom; rb = $urandom;
      for (int k = 0; k < 4; k++) begin
         run_op(2'(k), ra, rb, 1'b0);
         if (k == 0) chk("mul_low_consistency", result, ra * rb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Iterative shift-and-add multiplier implementing the RV32M ops MUL, MULH, MULHSU and MULHU.
- Sits beside the ALU in the execute stage and feeds the existing N-bit ripple-carry adder (RCA) each cycle, consuming its sum and carry-out as the partial product.
- Uses a start/busy/done handshake; the core stalls while busy is high.

Parameters:
- N, 32, operand and result width in bits (even, 4 or more).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- op  input  2  00 MUL (low half), 01 MULH (s×s high), 10 MULHSU (rs1 signed × rs2 unsigned, high), 11 MULHU (u×u high).
- rs1  input  N  multiplicand operand.
- rs2  input  N  multiplier operand.
- busy  output  1  high while an operation is in flight (CALC, SIGN).
- done  output  1  one-cycle pulse when result is valid.
- result  output  N  selected product half; held until the next accepted start.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, result=0, internal registers=0.
  - Reset asserted mid-operation aborts it with no done pulse.
- States and transitions:
  - IDLE: on start=1, latch op and neg = sign(rs1 as op-signed) XOR sign(rs2 as op-signed).
    - Latch mcand=|rs1| and mplier=|rs2|; magnitudes are taken only for operands signed under op, and 0x80..0 maps to 0x80..0 as unsigned.
    - Clear acc_hi and cnt; go to CALC.
  - CALC: each cycle the RCA computes acc_hi + (mplier[0] ? mcand : 0).
    - {carry, sum, mplier} is then shifted right by 1 into {acc_hi, mplier}, so acc_hi:mplier accumulates the 2N-bit product.
    - cnt increments; after N cycles (cnt==N-1) go to SIGN.
  - SIGN: if neg, replace prod = ~prod + 1 (2N-bit); go to DONE.
  - DONE: result = (op==MUL) ? prod[N-1:0] : prod[2N-1:N]; done=1 for this cycle only; go to IDLE.
- Latency:
  - The edge sampling start moves the block to CALC.
  - done is high in the cycle after edge N+1 counted from that sampling edge, i.e. N+2 cycles start-to-done; 34 cycles at N=32.
- busy=1 from the cycle after start is sampled through SIGN; busy=0 in IDLE and DONE.
- start while busy or in DONE is ignored and does not queue; it must be re-asserted in IDLE.
- op/rs1/rs2 are sampled only at start acceptance; later input changes have no effect.
- Operand of 0: runs full latency, result 0, sign fix of 0 stays 0.
- The MUL low half is independent of signedness; it must equal the low half for all op encodings.
- Counter width is clog2(N); cnt must not wrap within an operation.

Decomposition:
- Shared defines file holds:
  - op encodings MUL_OP_MUL/MULH/MULHSU/MULHU;
  - state encodings S_IDLE, S_CALC, S_SIGN, S_DONE.
- Sub-module: the existing N-bit RCA, one instance (parameter n=N) for the per-cycle partial-sum add.
- The two's-complement sign fix is a local expression; it needs no second sub-module.

Test Plan:
- MUL 7 × 6: start in IDLE -> busy high for 33 cycles, done pulse on cycle 34, result=0x0000002A, done low next cycle.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> result=0xFFFFFFFE; MUL with the same operands -> 0x00000001.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000.
- MULHSU 0xFFFFFFFE × 3 -> 0xFFFFFFFF; MULHU with the same operands -> 0x00000002.
- start pulsed and operands changed during CALC -> ignored, result still reflects the first operands, exactly one done pulse.
- rst asserted at CALC cycle 10 -> next cycle busy=0, done=0, result=0; a new MUL 3 × 5 then yields 0x0000000F.
